// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus sync,
// blanking and frame markers, all registered alongside the counts.
//
// Ports:
//   clk_25MHz   pixel clock, all state updates on its rising edge
//   reset       asynchronous active-high reset
//   pixel_en    advance enable; counters and outputs hold when low
//   h_count     current pixel column, 0..H_TOTAL-1
//   v_count     current line, 0..V_TOTAL-1
//   hsync       horizontal sync at HSYNC_POL while active
//   vsync       vertical sync at VSYNC_POL while active
//   video_on    high inside the visible area
//   line_end    high while h_count is the last column
//   frame_start one-cycle pulse when the counts wrap to (0,0)
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 29,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             pixel_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SY_LO = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SY_HI = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SY_LO = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SY_HI = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Parameter sanity: a zero-width porch or sync, or a total that
    // does not fit the counters, is rejected at elaboration.
    if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch/sync parameter is zero");
    end

    if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
        longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: total exceeds counter range");
    end

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hs_act;
    logic             vs_act;

    // ">=" rather than "==" so an out-of-range count (upset) recovers
    // to 0 on its next advance instead of running up to 2^CNT_W.
    assign h_wrap = (h_count >= H_LAST);
    assign v_wrap = (v_count >= V_LAST);

    always_comb begin
        h_nxt = h_count + CNT_W'(1);
        v_nxt = v_count;
        if (h_wrap) begin
            h_nxt = '0;
            v_nxt = v_wrap ? '0 : v_count + CNT_W'(1);
        end
    end

    // Decode from the next counts so the registered flags line up
    // with the registered counts in the same cycle.
    assign hs_act = (h_nxt >= H_SY_LO) && (h_nxt < H_SY_HI);
    assign vs_act = (v_nxt >= V_SY_LO) && (v_nxt < V_SY_HI);

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            video_on    <= 1'b1;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else if (pixel_en) begin
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            line_end    <= (h_nxt == H_LAST);
            frame_start <= h_wrap && v_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, a tiny
// active-high raster for frame-level checks, and an 800x600 set.
module tb_vga_timing_gen;

    logic clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    logic rst1, pen1, rst2, pen2, rst3, pen3;

    logic [15:0] h1, v1, h2, v2, h3, v3;
    logic hs1, vs1, von1, le1, fs1;
    logic hs2, vs2, von2, le2, fs2;
    logic hs3, vs3, von3, le3, fs3;

    int n_chk = 0;
    int n_bad = 0;

    vga_timing_gen dut1 (
        .clk_25MHz  (clk_25MHz),
        .reset      (rst1),
        .pixel_en   (pen1),
        .h_count    (h1),
        .v_count    (v1),
        .hsync      (hs1),
        .vsync      (vs1),
        .video_on   (von1),
        .line_end   (le1),
        .frame_start(fs1)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(16)
    ) dut2 (
        .clk_25MHz  (clk_25MHz),
        .reset      (rst2),
        .pixel_en   (pen2),
        .h_count    (h2),
        .v_count    (v2),
        .hsync      (hs2),
        .vsync      (vs2),
        .video_on   (von2),
        .line_end   (le2),
        .frame_start(fs2)
    );

    vga_timing_gen #(
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(16)
    ) dut3 (
        .clk_25MHz  (clk_25MHz),
        .reset      (rst3),
        .pixel_en   (pen3),
        .h_count    (h3),
        .v_count    (v3),
        .hsync      (hs3),
        .vsync      (vs3),
        .video_on   (von3),
        .line_end   (le3),
        .frame_start(fs3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_25MHz);
        #1;
    endtask

    initial begin
        int nlow, first_low, nle, le_h, nvon;
        int ndec, nfs, fs_k, nvs, vs_h, vs_v, nhs, nwide;
        int pos, eh, ev;
        logic prev_fs;

        rst1 = 1'b1; pen1 = 1'b0;
        rst2 = 1'b1; pen2 = 1'b0;
        rst3 = 1'b1; pen3 = 1'b0;
        #7;

        // Reset values, before any clock edge
        check("rst_h",  32'(h1), 0);
        check("rst_v",  32'(v1), 0);
        check("rst_hs", 32'(hs1), 1);
        check("rst_vs", 32'(vs1), 1);
        check("rst_von", 32'(von1), 1);
        check("rst_le", 32'(le1), 0);
        check("rst_fs", 32'(fs1), 0);
        check("rst_hs2", 32'(hs2), 0);
        check("rst_vs2", 32'(vs2), 0);
        check("rst_hs3", 32'(hs3), 0);

        // ---- default timing, single line ----
        tick; tick;
        rst1 = 1'b0; pen1 = 1'b1;
        tick;
        check("first_h", 32'(h1), 1);
        check("first_v", 32'(v1), 0);
        check("first_fs", 32'(fs1), 0);

        nlow = 0; first_low = -1; nle = 0; le_h = -1; nvon = 0;
        for (int i = 0; i < 800; i++) begin
            tick;
            if (!hs1) begin
                if (nlow == 0) first_low = int'(h1);
                nlow++;
            end
            if (le1) begin
                nle++;
                le_h = int'(h1);
            end
            if (von1) nvon++;
        end
        check("hs_low_cnt", 32'(nlow), 96);
        check("hs_first_h", 32'(first_low), 656);
        check("le_cnt", 32'(nle), 1);
        check("le_h", 32'(le_h), 799);
        check("von_cnt", 32'(nvon), 640);
        check("line_h", 32'(h1), 1);
        check("line_v", 32'(v1), 1);

        // ---- line wrap at (799,5) ----
        for (int i = 0; i < 3998; i++) tick;
        check("w_h", 32'(h1), 799);
        check("w_v", 32'(v1), 5);
        check("w_le", 32'(le1), 1);
        check("w_hs", 32'(hs1), 1);
        check("w_von", 32'(von1), 0);
        tick;
        check("w2_h", 32'(h1), 0);
        check("w2_v", 32'(v1), 6);
        check("w2_le", 32'(le1), 0);
        check("w2_von", 32'(von1), 1);

        // ---- hold with pixel_en low ----
        pen1 = 1'b0;
        tick; tick; tick;
        check("hold_h", 32'(h1), 0);
        check("hold_v", 32'(v1), 6);
        check("hold_von", 32'(von1), 1);
        check("hold_hs", 32'(hs1), 1);

        // ---- alternate enable: 10 advances in 20 cycles ----
        for (int i = 0; i < 10; i++) begin
            pen1 = 1'b1; tick;
            pen1 = 1'b0; tick;
        end
        check("tog_h", 32'(h1), 10);
        check("tog_v", 32'(v1), 6);

        // ---- small raster: two full frames against a model ----
        // H_TOTAL = 15, V_TOTAL = 8, hsync h 10..12, vsync v 5..6
        rst2 = 1'b0; pen2 = 1'b1;
        ndec = 0; nfs = 0; fs_k = -1; nvs = 0; vs_h = -1; vs_v = -1;
        nhs = 0; nvon = 0;
        for (int k = 1; k <= 240; k++) begin
            tick;
            eh = k % 15;
            ev = (k / 15) % 8;
            if (int'(h2) != eh || int'(v2) != ev) ndec++;
            if (hs2 !== (eh >= 10 && eh < 13)) ndec++;
            if (vs2 !== (ev >= 5 && ev < 7)) ndec++;
            if (von2 !== (eh < 8 && ev < 4)) ndec++;
            if (le2 !== (eh == 14)) ndec++;
            if (fs2 !== (k % 120 == 0)) ndec++;
            if (fs2) begin
                if (nfs == 0) fs_k = k;
                nfs++;
            end
            if (vs2) begin
                if (nvs == 0) begin
                    vs_h = int'(h2);
                    vs_v = int'(v2);
                end
                nvs++;
            end
            if (hs2) nhs++;
            if (von2) nvon++;
        end
        check("frm_decode", 32'(ndec), 0);
        check("frm_fs_cnt", 32'(nfs), 2);
        check("frm_fs_first", 32'(fs_k), 120);
        check("frm_vs_cnt", 32'(nvs), 60);
        check("frm_vs_h", 32'(vs_h), 0);
        check("frm_vs_v", 32'(vs_v), 5);
        check("frm_hs_cnt", 32'(nhs), 48);
        check("frm_von_cnt", 32'(nvon), 64);

        // ---- small raster: alternating enable over one frame ----
        ndec = 0; nfs = 0; nwide = 0; prev_fs = fs2;
        pos = 240;
        for (int j = 1; j <= 240; j++) begin
            pen2 = (j % 2 == 1);
            tick;
            if (pen2) pos++;
            eh = pos % 15;
            ev = (pos / 15) % 8;
            if (int'(h2) != eh || int'(v2) != ev) ndec++;
            if (hs2 !== (eh >= 10 && eh < 13)) ndec++;
            if (vs2 !== (ev >= 5 && ev < 7)) ndec++;
            if (von2 !== (eh < 8 && ev < 4)) ndec++;
            if (fs2 !== (pen2 && pos % 120 == 0)) ndec++;
            if (fs2) nfs++;
            if (fs2 && prev_fs) nwide++;
            prev_fs = fs2;
        end
        check("tog_decode", 32'(ndec), 0);
        check("tog_fs_cnt", 32'(nfs), 1);
        check("tog_fs_wide", 32'(nwide), 0);

        // ---- small raster: reset inside the sync region ----
        pen2 = 1'b1;
        for (int i = 0; i < 85; i++) tick;
        check("mid_h", 32'(h2), 10);
        check("mid_v", 32'(v2), 5);
        check("mid_hs", 32'(hs2), 1);
        check("mid_vs", 32'(vs2), 1);
        #5 rst2 = 1'b1;
        #1;
        check("arst_h", 32'(h2), 0);
        check("arst_v", 32'(v2), 0);
        check("arst_hs", 32'(hs2), 0);
        check("arst_vs", 32'(vs2), 0);
        check("arst_von", 32'(von2), 1);
        check("arst_le", 32'(le2), 0);
        check("arst_fs", 32'(fs2), 0);
        tick; tick;
        check("arst_prio_h", 32'(h2), 0);
        rst2 = 1'b0;
        tick;
        check("rel_h", 32'(h2), 1);
        check("rel_v", 32'(v2), 0);
        nfs = 0;
        for (int i = 0; i < 5; i++) begin
            if (fs2) nfs++;
            tick;
        end
        check("rel_no_fs", 32'(nfs), 0);

        // ---- 800x600, active-high syncs, one line ----
        rst3 = 1'b0; pen3 = 1'b1;
        nhs = 0; first_low = -1; nle = 0; le_h = -1;
        for (int k = 1; k <= 1056; k++) begin
            tick;
            if (hs3) begin
                if (nhs == 0) first_low = int'(h3);
                nhs++;
            end
            if (le3) begin
                nle++;
                le_h = int'(h3);
            end
        end
        check("svga_hs_cnt", 32'(nhs), 128);
        check("svga_hs_first", 32'(first_low), 840);
        check("svga_le_cnt", 32'(nle), 1);
        check("svga_le_h", 32'(le_h), 1055);
        check("svga_h", 32'(h3), 0);
        check("svga_v", 32'(v3), 1);
        check("svga_vs", 32'(vs3), 0);
        check("svga_von", 32'(von3), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 29, vertical back porch in lines.
REQ-009 Parameter HSYNC_POL, 0, active level of hsync (0 = active-low).
REQ-010 Parameter VSYNC_POL, 0, active level of vsync (0 = active-low).
REQ-011 Parameter CNT_W, 16, width of the count outputs.
REQ-012 clk_25MHz  input  1  pixel clock; all state SHALL update on its rising edge.
REQ-013 reset  input  1  asynchronous, active-high reset.
REQ-014 pixel_en  input  1  advance enable; counters SHALL step only when high.
REQ-015 h_count  output  CNT_W  current pixel column, 0..H_TOTAL-1.
REQ-016 v_count  output  CNT_W  current line, 0..V_TOTAL-1.
REQ-017 hsync, vsync  output  1 each  sync pulses at the parameterised polarity.
REQ-018 video_on  output  1  high while (h_count, v_count) lies in the visible area.
REQ-019 line_end  output  1  high while h_count = H_TOTAL-1.
REQ-020 frame_start  output  1  single-cycle pulse on frame wrap.

Function
REQ-021 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK; the defaults SHALL give 800 and 521.
REQ-022 With pixel_en high, h_count SHALL increment by 1 per cycle and wrap from H_TOTAL-1 to 0.
REQ-023 v_count SHALL increment only in the cycle in which h_count wraps, and SHALL itself wrap from V_TOTAL-1 to 0.
REQ-024 With pixel_en low, all counters and all outputs SHALL hold their values, except frame_start, which SHALL be driven 0.
REQ-025 hsync SHALL be at level HSYNC_POL exactly when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (default 656..751), and at the inverse level otherwise.
REQ-026 vsync SHALL be at level VSYNC_POL exactly when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), and at the inverse level otherwise; vsync SHALL be qualified by v_count only, not h_count.
REQ-027 hsync, vsync, video_on and line_end SHALL be registered and decoded from the next count values, so each is valid in the same cycle as the h_count/v_count it describes (zero cycles of skew to the counts).
REQ-028 frame_start SHALL be 1 for exactly one clock, in the cycle in which the counts become (0,0) by a wrap from (H_TOTAL-1, V_TOTAL-1); reaching (0,0) by reset SHALL NOT assert it.
REQ-029 Counter arithmetic SHALL be performed at CNT_W bits; a count SHALL never exceed its TOTAL-1 (a value >= TOTAL, e.g. after an SEU, SHALL wrap to 0 on the next advance).
REQ-030 Elaboration SHALL fail if any porch or sync parameter is 0, or if H_TOTAL or V_TOTAL exceeds 2^CNT_W.

Reset
REQ-031 While reset is high, regardless of clk_25MHz: h_count = 0, v_count = 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, video_on = 1, line_end = 0, frame_start = 0.
REQ-032 Reset asserted mid-line or mid-frame SHALL abort the frame immediately; after release, the first advance SHALL produce h_count = 1, v_count = 0.
REQ-033 Reset SHALL take priority over pixel_en.

Verification
REQ-034 Reset release, pixel_en = 1, defaults: hsync low for exactly 96 cycles per 800, first low at h_count = 656.
REQ-035 Full-frame run, defaults: frame_start period = 416800 cycles; vsync low for 1600 cycles starting at (0,490); video_on high for 307200 cycles per frame.
REQ-036 Line wrap: at (799,5) -> next cycle (0,6); line_end high only at h = 799.
REQ-037 pixel_en toggled 1 / 0 each cycle: counts advance every 2 cycles, outputs held while pixel_en low, frame_start never wider than 1 cycle.
REQ-038 Reset pulsed at (700,490): outputs return immediately to their reset values; no frame_start follows release.
REQ-039 Overrides HSYNC_POL = 1, VSYNC_POL = 1 and an 800x600 set (40/128/88, 1/4/23): totals 1056/628, sync pulses active-high.
